// File: rtl/wb_gpio_pkg.sv
// rtl/wb_gpio_pkg.sv - register map and edge encoding shared by the wb_gpio_irq block
package wb_gpio_pkg;

    localparam int REG_COUNT = 8;

    localparam logic [2:0] REG_DATA_IN  = 3'd0;
    localparam logic [2:0] REG_DATA_OUT = 3'd1;
    localparam logic [2:0] REG_DIR      = 3'd2;
    localparam logic [2:0] REG_MASK     = 3'd3;
    localparam logic [2:0] REG_EDGE     = 3'd4;
    localparam logic [2:0] REG_STATUS   = 3'd5;
    localparam logic [2:0] REG_OUT_SET  = 3'd6;
    localparam logic [2:0] REG_OUT_CLR  = 3'd7;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/gpio_in_cond.sv
// rtl/gpio_in_cond.sv - pin synchroniser, optional debounce filter (GPIO_DEBOUNCE_EN) and edge detect
module gpio_in_cond #(
    parameter int W        = 32,
    parameter int DB_CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pin,
    output logic [W-1:0] value,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [W-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [DB_CNT_W-1:0] CNT_ONE = 1;

    logic [W-1:0]        filt;
    logic [DB_CNT_W-1:0] cnt [W];

    // A pin must disagree with the filtered value for a full counter wrap before it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= '0;
            for (int i = 0; i < W; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (&cnt[i]) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign value = filt;
`else
    wire [DB_CNT_W-1:0] unused_db_cnt = '0;

    assign value = sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) prev <= '0;
        else     prev <= value;
    end

    assign rise = value & ~prev;
    assign fall = ~value & prev;

endmodule

// File: rtl/wb_gpio_irq.sv
// rtl/wb_gpio_irq.sv - Wishbone GPIO with set/clear outputs and masked edge interrupts
// Optional input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module wb_gpio_irq
    import wb_gpio_pkg::*;
#(
    parameter int                    GPIO_WIDTH   = 32,
    parameter int                    WB_ADR_WIDTH = 32,
    parameter logic [GPIO_WIDTH-1:0] DIR_RESET    = '0,
    parameter logic [GPIO_WIDTH-1:0] OUT_RESET    = '0,
    parameter int                    DB_CNT_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WB_ADR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]             wb_dat_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic [31:0]             wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    irq,
    inout  wire  [GPIO_WIDTH-1:0]   gpio_io
);

    localparam int IDX_W = $clog2(REG_COUNT);

    logic                  ack;
    logic                  req;
    logic                  wr;
    logic [IDX_W-1:0]      idx;
    logic [GPIO_WIDTH-1:0] wdata;
    logic [GPIO_WIDTH-1:0] w1c;
    logic [GPIO_WIDTH-1:0] evt;
    logic [31:0]           rdata;

    logic [GPIO_WIDTH-1:0] data_out_r;
    logic [GPIO_WIDTH-1:0] dir_r;
    logic [GPIO_WIDTH-1:0] mask_r;
    logic [GPIO_WIDTH-1:0] edge_r;
    logic [GPIO_WIDTH-1:0] status_r;
    logic [GPIO_WIDTH-1:0] data_in;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] fall;

    wire unused_bus = ^{wb_adr_i, wb_dat_i};

    assign idx      = wb_adr_i[4:2];
    assign req      = wb_cyc_i & wb_stb_i & ~ack;
    assign wr       = req & wb_we_i;
    assign wdata    = wb_dat_i[GPIO_WIDTH-1:0];
    assign w1c      = (wr && idx == REG_STATUS) ? wdata : '0;
    assign wb_ack_o = wb_cyc_i & wb_stb_i & ack;

    gpio_in_cond #(
        .W        (GPIO_WIDTH),
        .DB_CNT_W (DB_CNT_W)
    ) u_in_cond (
        .clk   (clk),
        .rst   (rst),
        .pin   (gpio_io),
        .value (data_in),
        .rise  (rise),
        .fall  (fall)
    );

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
        assign gpio_io[i] = dir_r[i] ? data_out_r[i] : 1'bz;
    end

    // Output pins never raise events, whatever their readback does.
    always_comb begin
        evt = '0;
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            evt[i] = ((edge_r[i] == EDGE_FALL) ? fall[i] : rise[i]) & ~dir_r[i];
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            REG_DATA_IN:  rdata[GPIO_WIDTH-1:0] = data_in;
            REG_DATA_OUT: rdata[GPIO_WIDTH-1:0] = data_out_r;
            REG_DIR:      rdata[GPIO_WIDTH-1:0] = dir_r;
            REG_MASK:     rdata[GPIO_WIDTH-1:0] = mask_r;
            REG_EDGE:     rdata[GPIO_WIDTH-1:0] = edge_r;
            REG_STATUS:   rdata[GPIO_WIDTH-1:0] = status_r;
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack        <= 1'b0;
            wb_dat_o   <= '0;
            data_out_r <= OUT_RESET;
            dir_r      <= DIR_RESET;
            mask_r     <= '0;
            edge_r     <= '0;
            status_r   <= '0;
            irq        <= 1'b0;
        end else begin
            ack      <= req;
            irq      <= |(status_r & mask_r);
            status_r <= (status_r & ~w1c) | evt;
            if (req) wb_dat_o <= rdata;
            if (wr) begin
                case (idx)
                    REG_DATA_OUT: data_out_r <= wdata;
                    REG_DIR:      dir_r      <= wdata;
                    REG_MASK:     mask_r     <= wdata;
                    REG_EDGE:     edge_r     <= wdata;
                    REG_OUT_SET:  data_out_r <= data_out_r | wdata;
                    REG_OUT_CLR:  data_out_r <= data_out_r & ~wdata;
                    default:      ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// tb/tb_wb_gpio_irq.sv - self-checking bench for wb_gpio_irq against a behavioural register/pin model
module tb_wb_gpio_irq;
    import wb_gpio_pkg::*;

    localparam int          W       = 32;
    localparam int          DBW     = 4;
    localparam logic [31:0] DIR_RST = 32'h0000_0010;
    localparam logic [31:0] OUT_RST = 32'h0000_00C3;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 2 + (1 << DBW);
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, wdat, rdat;
    logic        we, cyc, stb, ack, irq;
    wire  [W-1:0] pins;
    logic [W-1:0] tb_drv;
    logic         started;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: registers, pin sample delay line, conditioned input
    logic [W-1:0] m_out, m_dir, m_mask, m_edge, m_status, m_cond, m_prevc, m_evt, m_clr, sample;
    logic [W-1:0] hist [4];
    logic [31:0]  m_rd;
    logic         m_irq, m_ack;
    logic         mw_valid, mw_we;
    logic [2:0]   mw_idx;
    logic [31:0]  mw_dat;
`ifdef GPIO_DEBOUNCE_EN
    logic [W-1:0] m_filt;
    int           run [W];
`endif

    always #5 clk = ~clk;

    for (genvar i = 0; i < W; i++) begin : g_drv
        assign pins[i] = m_dir[i] ? 1'bz : tb_drv[i];
    end

    wb_gpio_irq #(
        .GPIO_WIDTH   (W),
        .WB_ADR_WIDTH (32),
        .DIR_RESET    (DIR_RST),
        .OUT_RESET    (OUT_RST),
        .DB_CNT_W     (DBW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_adr_i (adr),
        .wb_dat_i (wdat),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_dat_o (rdat),
        .wb_ack_o (ack),
        .irq      (irq),
        .gpio_io  (pins)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] read_model(input logic [2:0] idx);
        case (idx)
            REG_DATA_IN:  return m_cond;
            REG_DATA_OUT: return m_out;
            REG_DIR:      return m_dir;
            REG_MASK:     return m_mask;
            REG_EDGE:     return m_edge;
            REG_STATUS:   return m_status;
            default:      return 32'h0;
        endcase
    endfunction

    // Behavioural model: each posted bus op lands on the first edge after it is presented.
    always @(posedge clk) begin
        sample = (m_dir & m_out) | (~m_dir & tb_drv);
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sample;
        if (rst) begin
            m_out = OUT_RST; m_dir = DIR_RST; m_mask = '0; m_edge = '0; m_status = '0;
            m_cond = '0; m_prevc = '0; m_irq = 1'b0; m_ack = 1'b0; m_rd = '0;
            for (int i = 0; i < 4; i++) hist[i] = '0;
`ifdef GPIO_DEBOUNCE_EN
            m_filt = '0;
            for (int i = 0; i < W; i++) run[i] = 0;
`endif
        end else begin
            m_evt = ((m_edge & ~m_cond & m_prevc) | (~m_edge & m_cond & ~m_prevc)) & ~m_dir;
            m_ack = mw_valid;
            m_clr = '0;
            m_irq = |(m_status & m_mask);
            if (mw_valid) begin
                m_rd = read_model(mw_idx);
                if (mw_we) begin
                    case (mw_idx)
                        REG_DATA_OUT: m_out  = mw_dat;
                        REG_DIR:      m_dir  = mw_dat;
                        REG_MASK:     m_mask = mw_dat;
                        REG_EDGE:     m_edge = mw_dat;
                        REG_STATUS:   m_clr  = mw_dat;
                        REG_OUT_SET:  m_out  = m_out | mw_dat;
                        REG_OUT_CLR:  m_out  = m_out & ~mw_dat;
                        default:      ;
                    endcase
                end
            end
            m_status = (m_status & ~m_clr) | m_evt;
            m_prevc  = m_cond;
`ifdef GPIO_DEBOUNCE_EN
            for (int i = 0; i < W; i++) begin
                if (hist[2][i] != m_filt[i]) begin
                    run[i]++;
                    if (run[i] == (1 << DBW)) begin
                        m_filt[i] = hist[2][i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_cond = m_filt;
`else
            m_cond = hist[1];
`endif
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("ack", 32'(ack), 32'(m_ack));
            if (ack && m_ack) chk("rdata", rdat, m_rd);
            chk("irq", 32'(irq), 32'(m_irq));
            chk("pins_out", pins & m_dir, m_out & m_dir);
        end
    end

    task automatic bus(input logic w, input logic [2:0] idx, input logic [31:0] d, output logic [31:0] q);
        adr = {27'd0, idx, 2'b00}; wdat = d; we = w; cyc = 1'b1; stb = 1'b1;
        mw_valid = 1'b1; mw_we = w; mw_idx = idx; mw_dat = d;
        @(posedge clk); #1;
        mw_valid = 1'b0;
        q = rdat;
        chk("ack_latency", 32'(ack), 32'd1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        logic [31:0] q;
        bus(1'b1, idx, d, q);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        rst = 1'b1; adr = '0; wdat = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        tb_drv = '0; mw_valid = 1'b0; mw_we = 1'b0; mw_idx = '0; mw_dat = '0; started = 1'b0;
        cycles(3);
        rst = 1'b0; started = 1'b1;

        chk("reset_irq", 32'(irq), 32'd0);
        for (int i = 0; i < REG_COUNT; i++) begin
            bus(1'b0, 3'(i), 32'h0, q);
            chk("reset_reg", q, (i == 1) ? 32'h0000_00C3 : (i == 2) ? 32'h0000_0010 : 32'h0);
        end

        tb_drv = 32'h5A5A_5800;
        wr(REG_DIR, 32'h0000_00FF);
        wr(REG_DATA_OUT, 32'h0000_00A5);
        wr(REG_OUT_SET, 32'h0000_000A);
        wr(REG_OUT_CLR, 32'h0000_0081);
        cycles(LAT + 3);
        chk("pins_low_byte", 32'(pins[7:0]), 32'h2E);
        bus(1'b0, REG_DATA_OUT, 32'h0, q); chk("data_out_setclr", q, 32'h0000_002E);
        bus(1'b0, REG_DATA_IN, 32'h0, q);  chk("data_in_mixed", q, 32'h5A5A_582E);
        bus(1'b0, REG_OUT_SET, 32'h0, q);  chk("out_set_reads0", q, 32'h0);
        wr(REG_STATUS, 32'hFFFF_FFFF);
        bus(1'b0, REG_STATUS, 32'h0, q);   chk("status_cleared", q, 32'h0);

        wr(REG_MASK, 32'h0000_0100);
        wr(REG_EDGE, 32'h0);
        tb_drv[8] = 1'b1;
        cycles(LAT + 1);
        chk("irq_not_yet", 32'(irq), 32'd0);
        cycles(1);
        chk("irq_rise8", 32'(irq), 32'd1);
        bus(1'b0, REG_STATUS, 32'h0, q);   chk("status_rise8", q, 32'h0000_0100);
        adr = {27'd0, REG_STATUS, 2'b00}; wdat = 32'h100; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        mw_valid = 1'b1; mw_we = 1'b1; mw_idx = REG_STATUS; mw_dat = 32'h100;
        @(posedge clk); #1;
        mw_valid = 1'b0;
        chk("irq_after_w1c_1", 32'(irq), 32'd1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("irq_after_w1c_2", 32'(irq), 32'd0);

        tb_drv[8] = 1'b0; cycles(LAT + 3);
        tb_drv[8] = 1'b1; cycles(LAT + 3);
        tb_drv[8] = 1'b0; cycles(LAT + 3);
        chk("irq_sticky", 32'(irq), 32'd1);
        tb_drv[8] = 1'b1;
        cycles(LAT);
        wr(REG_STATUS, 32'h0000_0100);
        chk("irq_set_wins", 32'(irq), 32'd1);
        bus(1'b0, REG_STATUS, 32'h0, q);   chk("status_set_wins", q, 32'h0000_0100);

        wr(REG_MASK, 32'h0);
        chk("irq_masked", 32'(irq), 32'd0);
        wr(REG_STATUS, 32'h0000_0100);

        wr(REG_EDGE, 32'h0000_0200);
        tb_drv[9] = 1'b1; cycles(LAT + 3);
        bus(1'b0, REG_STATUS, 32'h0, q);   chk("fall_ignores_rise", q, 32'h0);
        tb_drv[9] = 1'b0; cycles(LAT + 3);
        bus(1'b0, REG_STATUS, 32'h0, q);   chk("fall_sets", q, 32'h0000_0200);

        rst = 1'b1;
        adr = {27'd0, REG_DATA_OUT, 2'b00}; wdat = 32'h33; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ack", 32'(ack), 32'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        cycles(LAT + 3);
        bus(1'b0, REG_DATA_OUT, 32'h0, q); chk("rst_mid_data_out", q, 32'h0000_00C3);
        bus(1'b0, REG_DIR, 32'h0, q);      chk("rst_mid_dir", q, 32'h0000_0010);

`ifdef GPIO_DEBOUNCE_EN
        cycles(LAT + 3);
        wr(REG_STATUS, 32'hFFFF_FFFF);
        tb_drv[3] = 1'b1; cycles(10);
        tb_drv[3] = 1'b0; cycles(LAT + 3);
        bus(1'b0, REG_DATA_IN, 32'h0, q);  chk("glitch_data_in3", 32'(q[3]), 32'd0);
        bus(1'b0, REG_STATUS, 32'h0, q);   chk("glitch_status", q, 32'h0);
        tb_drv[3] = 1'b1; cycles(17);
        bus(1'b0, REG_DATA_IN, 32'h0, q);  chk("db_before_18", 32'(q[3]), 32'd0);
        tb_drv[3] = 1'b0; cycles(LAT + 3);
        tb_drv[3] = 1'b1; cycles(18);
        bus(1'b0, REG_DATA_IN, 32'h0, q);  chk("db_at_18", 32'(q[3]), 32'd1);
`endif

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
